countgen_sequencer: RTL
=======================

# countgen_sequencer

Programmable period sequencer that drives a `countgen_generator` instance. It holds a small table of (period, duration) entries and plays them in order, presenting each period to the generator's `period` input. It restarts the generator cleanly at every entry boundary, and it can stop or loop at the end of the table. It sits between the register/config interface and the generator, so software can schedule tone or pulse patterns without cycle-accurate writes.

## Interface
- `DEPTH`, 8: number of table entries (power of two, ≥2).
- `AW`, 3: table address width, equal to log2(DEPTH).
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cfg_we` input 1: table write strobe.
- `cfg_addr` input AW: table entry to write.
- `cfg_period` input 32: period value for the entry, passed unchanged to the generator.
- `cfg_duration` input 32: entry length in clk cycles; 0 is treated as 1.
- `cfg_last` input 1: marks the entry as the end of the sequence.
- `start` input 1: level-sampled; begins playback at entry 0 when idle.
- `stop` input 1: aborts playback.
- `loop_en` input 1: when high at the end of the sequence, playback wraps to entry 0.
- `period` output 32: period for the generator.
- `gen_rst` output 1: active-high synchronous reset for the generator.
- `busy` output 1: high while playing.
- `done` output 1: one-cycle pulse when a non-looping sequence completes.
- `cur_index` output AW: entry currently playing.

## Operation
- States are IDLE and RUN.
- Reset values: state IDLE, `period`=0, `gen_rst`=1, `busy`=0, `done`=0, `cur_index`=0, and every table entry is {period 0, duration 0, last 0}.
- In IDLE:
  - `gen_rst`=1, so the generator output is held at 0.
  - `period` holds its last value.
  - `start`=1 and `stop`=0 → load entry 0 and enter RUN.
- Loading entry i takes one edge and does the following:
  - `period`←table[i].period.
  - `dur_cnt`←max(duration,1)−1.
  - `cur_index`←i.
  - `gen_rst`←1 for exactly that one cycle.
- In RUN with `dur_cnt`≠0:
  - `dur_cnt` decrements.
  - `gen_rst`=0.
- In RUN with `dur_cnt`=0 (end of the entry):
  - If the entry is last (its `last` bit is set or i=DEPTH−1) and `loop_en`=1 → load entry 0.
  - If the entry is last and `loop_en`=0 → go to IDLE, pulse `done`=1 for one cycle, and set `gen_rst`=1.
  - Otherwise → load entry i+1.
- Each entry therefore occupies exactly max(duration,1) cycles; there are no gap cycles between entries.
- `stop`=1 in RUN → IDLE on the next edge with `gen_rst`=1 and no `done` pulse. `stop` has priority over `start` and over entry advance.
- `start` while in RUN is ignored.
- `done` and a new start can occur on consecutive cycles only; `start` is sampled in IDLE.
- Table writes:
  - They are accepted in any state and take effect one edge later.
  - Entry values are captured when the entry is loaded, so writing to the currently playing entry affects only its next play.
  - A write to entry i on the same edge that loads entry i: the load uses the old value.
- Arithmetic: 32-bit unsigned. `dur_cnt` never underflows. `period` is not range-checked; 0 and 1 pass through unchanged.
- `busy`=1 exactly when the state is RUN.

## Timing
- Latency from `start` to the first `period`/`gen_rst` update is 1 cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Table read is asynchronous from flops, and the result is registered into `period`.
- Asserting `rst` mid-sequence forces the reset values immediately, regardless of clock.

## Structure
- Package `countgen_pkg` holds:
  - the state enum {IDLE, RUN};
  - the entry struct {period[31:0], duration[31:0], last};
  - constants PERIOD_W=32 and DUR_W=32.
- Sub-module `countgen_seq_table` is a DEPTH×65-bit flop register file with one write port, one asynchronous read port and asynchronous reset to 0.
- The top level contains the FSM, the duration counter and the output registers.

## Test plan
- **Three-entry sequence:** program {10,5},{4,3},{6,2,last}, `loop_en`=0, pulse `start` → `period` reads 10 for 5 cycles, 4 for 3, 6 for 2. `gen_rst` is high on the first cycle of each entry. `done` pulses on cycle 11 after start. Then IDLE with `gen_rst`=1.
- **Loop:** same table with `loop_en`=1 → `cur_index` follows 0,1,2,0,1… with a 10-cycle period and no `done`. Drop `loop_en` → `done` follows entry 2.
- **Duration 0 and default end:** duration 0 plays for 1 cycle. A full table with no `last` bit runs all DEPTH entries and ends after entry 7.
- **Stop:** `stop` in mid-entry 1 → IDLE next edge, `busy`=0, `gen_rst`=1, no `done`. `start` and `stop` in the same cycle → stays IDLE.
- **Write during play:** write entry 1 period=99 while entry 1 plays → the current play is unchanged. The next loop iteration shows 99.
- **Async reset:** assert `rst`=0 mid-sequence between clock edges → all outputs return to reset values immediately. Afterwards, `start` plays an empty table: period 0, 1 cycle per entry, DEPTH entries.

Source files
------------

// File: rtl/countgen_pkg.sv
// Shared types and constants for the countgen period sequencer and its table.
package countgen_pkg;

    localparam int PERIOD_W = 32;
    localparam int DUR_W    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [DUR_W-1:0]    duration;
        logic                last;
    } entry_t;

    // A zero duration still occupies one cycle, so the counter start is max(d,1)-1.
    function automatic logic [DUR_W-1:0] dur_load(input logic [DUR_W-1:0] dur);
        if (dur == {DUR_W{1'b0}}) begin
            return {DUR_W{1'b0}};
        end else begin
            return dur - 32'd1;
        end
    endfunction

endpackage

// File: rtl/countgen_sequencer_if.sv
// Config, control and generator-facing signals of the period sequencer.
interface countgen_sequencer_if #(
    parameter int AW = 3
);
    import countgen_pkg::*;

    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic [PERIOD_W-1:0] cfg_period;
    logic [DUR_W-1:0]    cfg_duration;
    logic                cfg_last;
    logic                start;
    logic                stop;
    logic                loop_en;
    logic [PERIOD_W-1:0] period;
    logic                gen_rst;
    logic                busy;
    logic                done;
    logic [AW-1:0]       cur_index;

    modport master (
        output cfg_we, cfg_addr, cfg_period, cfg_duration, cfg_last,
        output start, stop, loop_en,
        input  period, gen_rst, busy, done, cur_index
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_period, cfg_duration, cfg_last,
        input  start, stop, loop_en,
        output period, gen_rst, busy, done, cur_index
    );

endinterface

// File: rtl/countgen_seq_table.sv
// Flop-based entry table: one synchronous write port, one asynchronous read port.
module countgen_seq_table
    import countgen_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);

    entry_t r_mem [DEPTH];

    // Table storage, cleared to all-zero entries on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/countgen_sequencer.sv
// Plays a table of (period, duration) entries into a countgen generator,
// restarting the generator at every entry boundary.
module countgen_sequencer
    import countgen_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    countgen_sequencer_if.slave bus
);

    state_t              r_state;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic                r_gen_rst;
    logic                r_busy;
    logic                r_done;
    logic [AW-1:0]       r_cur_index;
    logic                r_last;

    state_t              w_state_nxt;
    logic                w_load;
    logic [AW-1:0]       w_load_idx;
    logic                w_done_nxt;
    logic [DUR_W-1:0]    w_dur_nxt;
    logic                w_is_last;
    entry_t              w_wr_entry;
    entry_t              w_rd_entry;

    assign w_wr_entry = '{period:   bus.cfg_period,
                          duration: bus.cfg_duration,
                          last:     bus.cfg_last};

    countgen_seq_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .i_we    (bus.cfg_we),
        .i_waddr (bus.cfg_addr),
        .i_wdata (w_wr_entry),
        .i_raddr (w_load_idx),
        .o_rdata (w_rd_entry)
    );

    // The last bit is latched at load time; the final slot ends the sequence regardless.
    assign w_is_last = r_last || (r_cur_index == AW'(DEPTH - 1));

    // Next-state, entry-load and done decisions; stop outranks start and advance.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_idx  = r_cur_index;
        w_done_nxt  = 1'b0;
        w_dur_nxt   = r_dur_cnt;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_load      = 1'b1;
                    w_load_idx  = {AW{1'b0}};
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                end else if (r_dur_cnt != {DUR_W{1'b0}}) begin
                    w_dur_nxt = r_dur_cnt - 32'd1;
                end else if (w_is_last) begin
                    if (bus.loop_en) begin
                        w_load     = 1'b1;
                        w_load_idx = {AW{1'b0}};
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_load     = 1'b1;
                    w_load_idx = r_cur_index + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, duration counter and registered outputs; table data is captured on load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_dur_cnt   <= {DUR_W{1'b0}};
            r_period    <= {PERIOD_W{1'b0}};
            r_gen_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cur_index <= {AW{1'b0}};
            r_last      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt == RUN);
            r_gen_rst <= (w_state_nxt == IDLE) || w_load;
            r_done    <= w_done_nxt;
            if (w_load) begin
                r_period    <= w_rd_entry.period;
                r_dur_cnt   <= dur_load(w_rd_entry.duration);
                r_cur_index <= w_load_idx;
                r_last      <= w_rd_entry.last;
            end else begin
                r_dur_cnt   <= w_dur_nxt;
            end
        end
    end

    assign bus.period    = r_period;
    assign bus.gen_rst   = r_gen_rst;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cur_index = r_cur_index;

endmodule
